// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end of the 8-bit,
// 4-register BPF-style core.
// Contents: opcode constants, front-end state enum, instruction class enum
// and instruction field positions (16-bit format: op | dst | src | imm).
package bpf_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 10;
    localparam int SRC_MSB = 9;
    localparam int SRC_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LDI  = 3'd2,
        CLS_JMP  = 3'd3,
        CLS_JZ   = 3'd4,
        CLS_HALT = 3'd5
    } op_class_e;

endpackage

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode stage and its surroundings: instruction
// memory (address out, data in), register file view (in) and the issue
// tuple towards execute (out).
//   master : the fetch/decode stage
//   slave  : memory / register file / execute side
interface fetch_decode_if #(
    parameter int PC_W  = 8,
    parameter int NREGS = 4
);
    logic [PC_W-1:0]    imem_addr;
    logic [15:0]        imem_data;
    logic [8*NREGS-1:0] regs;
    logic               out_valid;
    logic [3:0]         opcode;
    logic [7:0]         in1_val;
    logic [7:0]         in2_val;
    logic [1:0]         dst_idx;
    logic               halted;

    modport master (
        output imem_addr, out_valid, opcode, in1_val, in2_val, dst_idx, halted,
        input  imem_data, regs
    );

    modport slave (
        input  imem_addr, out_valid, opcode, in1_val, in2_val, dst_idx, halted,
        output imem_data, regs
    );
endinterface

// File: rtl/fetch_decode_decode.sv
// Combinational instruction decoder.
// Ports:
//   i_instr       16-bit instruction word
//   o_class       instruction class (NOP/ALU/LDI/JMP/JZ/HALT)
//   o_op          raw opcode field
//   o_dst/o_src   register index fields
//   o_imm         immediate field
//   o_reads_dst   instruction reads register dst
//   o_reads_src   instruction reads register src
//   o_writes      instruction writes register dst in execute
//   o_is_jump     JMP or JZ
module instr_decode
    import bpf_pkg::*;
(
    input  logic [15:0] i_instr,
    output op_class_e   o_class,
    output logic [3:0]  o_op,
    output logic [1:0]  o_dst,
    output logic [1:0]  o_src,
    output logic [7:0]  o_imm,
    output logic        o_reads_dst,
    output logic        o_reads_src,
    output logic        o_writes,
    output logic        o_is_jump
);

    assign o_op  = i_instr[OP_MSB:OP_LSB];
    assign o_dst = i_instr[DST_MSB:DST_LSB];
    assign o_src = i_instr[SRC_MSB:SRC_LSB];
    assign o_imm = i_instr[IMM_MSB:IMM_LSB];

    // Classify the opcode; reserved opcodes 10-14 fall to NOP
    always_comb begin
        o_class     = CLS_NOP;
        o_reads_dst = 1'b0;
        o_reads_src = 1'b0;
        o_writes    = 1'b0;
        o_is_jump   = 1'b0;
        case (o_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                o_class     = CLS_ALU;
                o_reads_dst = 1'b1;
                o_reads_src = 1'b1;
                o_writes    = 1'b1;
            end
            OP_LDI: begin
                o_class     = CLS_LDI;
                o_reads_dst = 1'b1;
                o_writes    = 1'b1;
            end
            OP_JMP: begin
                o_class   = CLS_JMP;
                o_is_jump = 1'b1;
            end
            OP_JZ: begin
                o_class     = CLS_JZ;
                o_reads_dst = 1'b1;
                o_is_jump   = 1'b1;
            end
            OP_HALT: begin
                o_class = CLS_HALT;
            end
            default: begin
                o_class = CLS_NOP;
            end
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: holds the PC, fetches one instruction per cycle,
// reads operands and issues {opcode, in1_val, in2_val, dst_idx} to execute
// one cycle after fetch. Resolves jumps locally, stalls one cycle on a
// read-after-write against the previously issued write, stops on HALT.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   i_en   run enable; 0 holds PC/state and issues bubbles
//   bus    fetch_decode_if master (imem, regs, issue tuple, halted)
module fetch_decode
    import bpf_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int NREGS = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    fetch_decode_if.master bus
);

    state_e          r_state;
    state_e          w_nxt_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_nxt_pc;
    logic            r_last_wr;
    logic            w_nxt_last_wr;
    logic [1:0]      r_last_dst;
    logic [1:0]      w_nxt_last_dst;

    logic            r_out_valid;
    logic [3:0]      r_opcode;
    logic [7:0]      r_in1_val;
    logic [7:0]      r_in2_val;
    logic [1:0]      r_dst_idx;
    logic            r_halted;

    logic            w_nxt_valid;
    logic [3:0]      w_nxt_opcode;
    logic [7:0]      w_nxt_in1;
    logic [7:0]      w_nxt_in2;
    logic [1:0]      w_nxt_dst;
    logic            w_nxt_halted;

    op_class_e       w_class;
    logic [3:0]      w_op;
    logic [1:0]      w_dst;
    logic [1:0]      w_src;
    logic [7:0]      w_imm;
    logic            w_reads_dst;
    logic            w_reads_src;
    logic            w_writes;
    logic            w_is_jump;

    logic [7:0]      w_reg_arr [NREGS];
    logic [7:0]      w_dst_val;
    logic [7:0]      w_src_val;
    logic            w_hazard;
    logic            w_decoding;
    logic            w_take_jump;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;

    instr_decode u_decode (
        .i_instr     (bus.imem_data),
        .o_class     (w_class),
        .o_op        (w_op),
        .o_dst       (w_dst),
        .o_src       (w_src),
        .o_imm       (w_imm),
        .o_reads_dst (w_reads_dst),
        .o_reads_src (w_reads_src),
        .o_writes    (w_writes),
        .o_is_jump   (w_is_jump)
    );

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        assign w_reg_arr[g] = bus.regs[8*g +: 8];
    end

    assign w_dst_val   = w_reg_arr[w_dst];
    assign w_src_val   = w_reg_arr[w_src];
    assign w_pc_inc    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_target    = PC_W'(w_imm);
    assign w_take_jump = w_is_jump && ((w_class == CLS_JMP) || (w_dst_val == 8'd0));

    // The previous issue writes a register execute has not yet committed.
    // last_wr is cleared by every bubble, so the cycle spent in STALL can
    // never raise the hazard again and re-decodes with fresh regs.
    assign w_hazard = r_last_wr &&
                      ((w_reads_dst && (w_dst == r_last_dst)) ||
                       (w_reads_src && (w_src == r_last_dst)));

    // STALL decodes exactly like RUN; it only exists to mark the held cycle.
    assign w_decoding = i_en && ((r_state == RUN) || (r_state == STALL));

    // State register: PC, FSM state and hazard tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_pc       <= '0;
            r_last_wr  <= 1'b0;
            r_last_dst <= 2'd0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_last_wr  <= w_nxt_last_wr;
            r_last_dst <= w_nxt_last_dst;
        end
    end

    // Next-state logic: PC update, FSM transitions and hazard tracking
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_last_wr  = r_last_wr;
        w_nxt_last_dst = r_last_dst;
        if (w_decoding) begin
            if (w_hazard) begin
                w_nxt_state   = STALL;
                w_nxt_last_wr = 1'b0;
            end else begin
                w_nxt_state    = RUN;
                w_nxt_last_wr  = w_writes;
                w_nxt_last_dst = w_dst;
                case (w_class)
                    CLS_HALT: begin
                        w_nxt_state = HALT;
                        w_nxt_pc    = r_pc;
                    end
                    CLS_JMP, CLS_JZ: begin
                        w_nxt_pc = w_take_jump ? w_target : w_pc_inc;
                    end
                    default: begin
                        w_nxt_pc = w_pc_inc;
                    end
                endcase
            end
        end else if (i_en && (r_state == HALT)) begin
            w_nxt_last_wr = 1'b0;
        end else if (i_en) begin
            // Unreachable encoding: recover to RUN
            w_nxt_state   = RUN;
            w_nxt_last_wr = 1'b0;
        end else begin
            w_nxt_state = r_state;
        end
    end

    // Output logic: next value of the registered issue tuple
    always_comb begin
        w_nxt_valid  = 1'b0;
        w_nxt_opcode = OP_NOP;
        w_nxt_in1    = 8'd0;
        w_nxt_in2    = 8'd0;
        w_nxt_dst    = 2'd0;
        w_nxt_halted = r_halted;
        if (w_decoding && !w_hazard) begin
            case (w_class)
                CLS_ALU: begin
                    w_nxt_valid  = 1'b1;
                    w_nxt_opcode = w_op;
                    w_nxt_in1    = w_dst_val;
                    w_nxt_in2    = w_src_val;
                    w_nxt_dst    = w_dst;
                end
                CLS_LDI: begin
                    // Execute sees LDI as MOV of the immediate
                    w_nxt_valid  = 1'b1;
                    w_nxt_opcode = OP_MOV;
                    w_nxt_in1    = w_dst_val;
                    w_nxt_in2    = w_imm;
                    w_nxt_dst    = w_dst;
                end
                CLS_HALT: begin
                    w_nxt_halted = 1'b1;
                end
                default: begin
                    w_nxt_valid = 1'b0;
                end
            endcase
        end else begin
            w_nxt_valid = 1'b0;
        end
    end

    // Issue output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_opcode    <= OP_NOP;
            r_in1_val   <= 8'd0;
            r_in2_val   <= 8'd0;
            r_dst_idx   <= 2'd0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= w_nxt_valid;
            r_opcode    <= w_nxt_opcode;
            r_in1_val   <= w_nxt_in1;
            r_in2_val   <= w_nxt_in2;
            r_dst_idx   <= w_nxt_dst;
            r_halted    <= w_nxt_halted;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.opcode    = r_opcode;
    assign bus.in1_val   = r_in1_val;
    assign bus.in2_val   = r_in2_val;
    assign bus.dst_idx   = r_dst_idx;
    assign bus.halted    = r_halted;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Front-end stage of the 8-bit, 4-register BPF-style core, directly upstream of the execute stage.
- Holds the PC and fetches one 16-bit instruction per cycle from a combinational-read instruction memory.
- Decodes the instruction, reads operands from the architectural register vector and issues {opcode, in1_val, in2_val, dst_idx} to execute.
- Resolves jumps locally, detects the one-cycle read-after-write hazard against execute's register update, and stops on HALT.

Parameters:
- PC_W, 8, PC and imem address width; PC wraps modulo 2^PC_W.
- NREGS, 4, number of architectural registers; dst/src fields are log2(NREGS) bits.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; 0 freezes PC/state and issues bubbles.
- imem_addr  out  PC_W  equals current PC (combinational from PC register).
- imem_data  in  16  instruction at imem_addr, same cycle.
- regs  in  8*NREGS  current register file, same packing as execute's regs; reg i at bits [8i+7:8i].
- out_valid  out  1  issued instruction is real (0 = bubble).
- opcode  out  4  ALU opcode to execute.
- in1_val  out  8  operand 1 (value of dst register).
- in2_val  out  8  operand 2 (src register or immediate).
- dst_idx  out  2  destination register index.
- halted  out  1  core stopped on HALT.

Behaviour:
- Instruction format: [15:12] op, [11:10] dst, [9:8] src, [7:0] imm.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV (ALU passes in2), 7 LDI, 8 JMP, 9 JZ, 15 HALT; 10-14 are decoded as NOP.
- Reset: PC=0, state=RUN, out_valid=0, opcode=0, in1_val=0, in2_val=0, dst_idx=0, halted=0. rst overrides everything, including mid-STALL or HALT.
- Bubble: out_valid=0, opcode=NOP, in1_val=0, in2_val=0, dst_idx=0.
- All outputs are registered; one-cycle latency from fetch to issue.
- States:
  - RUN: normal fetch/decode/issue.
  - STALL: one bubble cycle, PC held; next state RUN.
  - HALT: absorbing until rst.
- Operand selection in RUN with en=1:
  - ALU ops 1-6: in1_val=regs[dst], in2_val=regs[src], opcode=op, dst_idx=dst, out_valid=1, PC+1.
  - LDI: opcode=6, in2_val=imm, in1_val=regs[dst], out_valid=1, PC+1.
  - NOP: bubble, PC+1.
  - JMP: bubble, PC=imm[PC_W-1:0].
  - JZ: bubble; PC=imm if regs[dst]==0, else PC+1.
  - HALT: bubble, halted=1, go to HALT; PC stays at the HALT address.
- Hazard:
  - Tracking: keep last_wr (previous issue had out_valid=1 and op 1-7) and last_dst.
  - Trigger: if last_wr and the current instruction reads last_dst, issue a bubble, hold PC and enter STALL.
  - Reads: ALU ops 1-6 read dst and src; LDI reads dst; JZ reads dst.
  - Resolution: after STALL the same PC is re-decoded with updated regs.
  - last_wr clears on any bubble, so a STALL never repeats back-to-back for the same instruction.
- en=0: bubble, PC, state and last_* held.
- en=0 during STALL: STALL is held, not consumed.
- PC arithmetic: PC+1 wraps 2^PC_W-1 -> 0. Jump targets are truncated to PC_W bits.

Decomposition:
- Package bpf_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - state enum {RUN, STALL, HALT};
  - instruction field position constants.
- Sub-module: one combinational decoder, instr_decode (instr -> op class, reads_dst, reads_src, writes, is_jump).
- PC, state and hazard logic live in fetch_decode.

Test Plan:
- Reset, then ADD r1,r2 with regs r1=3, r2=4 -> next cycle out_valid=1, opcode=1, in1_val=3, in2_val=4, dst_idx=1; imem_addr=1.
- LDI r0,#200 followed by ADD r1,r0 -> LDI issued; next cycle bubble with imem_addr held at 1; then ADD issued reading the updated r0=200.
- JZ r2,#0x40 with r2=0 -> bubble and imem_addr=0x40; repeat with r2=5 -> imem_addr=PC+1.
- PC=0xFF holding ADD -> issued, imem_addr wraps to 0x00.
- HALT at PC=5 -> halted=1, only bubbles and imem_addr=5 for 10 cycles; rst pulse -> halted=0, imem_addr=0.
- en=0 for 3 cycles mid-program, including during STALL -> bubbles with PC frozen; on en=1, execution resumes with no instruction lost or duplicated.
